// File: rtl/spi_slave_stream.sv
// SPI slave bridging a CPOL/CPHA-configurable SPI bus to valid/ready word streams on clk.
// Each direction has a one-word holding register, with underrun/overflow pulses and mid-word abort.
module spi_slave_stream #(
    parameter int                DATA_W      = 8,
    parameter bit                CPOL        = 1'b1,
    parameter bit                CPHA        = 1'b1,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_WORD   = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              tx_udf,
    output logic              rx_ovf
);

    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] scl_sync, ss_sync, mosi_sync;
    logic scl_s, ss_s, mosi_s, scl_d, ss_d;
    logic leading, trailing, sample_edge, launch_edge, ss_fall;
    logic frame_start, abort, do_sample, do_launch, word_done, word_load;
    logic tx_take, rx_take, tx_full;
    logic [DATA_W-1:0] tx_shreg, tx_hold, rx_shreg, rx_word;
    logic [CNT_W-1:0]  bit_cnt;

    // ss synchroniser resets low so a select already asserted at reset release is not seen as a fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync  <= {SYNC_STAGES{CPOL}};
            ss_sync   <= '0;
            mosi_sync <= '0;
            scl_d     <= CPOL;
            ss_d      <= 1'b0;
        end else begin
            scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            scl_d     <= scl_s;
            ss_d      <= ss_s;
        end
    end

    assign scl_s       = scl_sync[SYNC_STAGES-1];
    assign ss_s        = ss_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign leading     = (scl_d == CPOL) && (scl_s != CPOL);
    assign trailing    = (scl_d != CPOL) && (scl_s == CPOL);
    assign sample_edge = CPHA ? trailing : leading;
    assign launch_edge = CPHA ? leading : trailing;
    assign ss_fall     = ss_d && !ss_s;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        abort       = 1'b0;
        do_sample   = 1'b0;
        do_launch   = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_next  = ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_s) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end else begin
                    do_sample = sample_edge;
                    do_launch = launch_edge;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign word_done = do_sample && (bit_cnt == LAST_BIT);
    assign word_load = frame_start || word_done;
    assign rx_word   = {rx_shreg[DATA_W-2:0], mosi_s};
    assign tx_ready  = !tx_full;
    assign tx_take   = tx_valid && tx_ready;
    assign rx_take   = rx_valid && rx_ready;
    assign miso      = tx_shreg[DATA_W-1];
    assign miso_oe   = (state == ACTIVE);

    // Launch after a load is suppressed (bit_cnt==0) because the load already put the MSB on miso.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shreg <= '0;
            tx_hold  <= '0;
            tx_full  <= 1'b0;
            rx_shreg <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            bit_cnt  <= '0;
            tx_udf   <= 1'b0;
            rx_ovf   <= 1'b0;
        end else begin
            tx_udf <= 1'b0;
            rx_ovf <= 1'b0;

            if (tx_take) begin
                tx_hold <= tx_data;
                tx_full <= 1'b1;
            end else if (word_load) begin
                tx_full <= 1'b0;
            end

            if (word_load) begin
                tx_shreg <= tx_full ? tx_hold : IDLE_WORD;
                tx_udf   <= !tx_full;
            end else if (do_launch && (bit_cnt != '0)) begin
                tx_shreg <= {tx_shreg[DATA_W-2:0], 1'b0};
            end

            if (abort || frame_start) begin
                bit_cnt  <= '0;
                rx_shreg <= '0;
            end else if (do_sample) begin
                rx_shreg <= rx_word;
                bit_cnt  <= word_done ? '0 : bit_cnt + 1'b1;
            end

            if (word_done && (!rx_valid || rx_ready)) begin
                rx_data  <= rx_word;
                rx_valid <= 1'b1;
            end else begin
                if (word_done) rx_ovf <= 1'b1;
                if (rx_take)   rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_stream.sv
// Self-checking bench: one spi_slave_stream per CPOL/CPHA mode, driven by a bit-banged SPI master.
// Expected words and flag counts come from a transaction-level model of holding registers.
module tb_spi_slave_stream;

    localparam int HALF = 50;

    typedef logic [7:0] word3_t [3];

    typedef struct {
        int         mode;
        bit         preload;
        logic [7:0] txw;
        logic [7:0] mo;
        logic [7:0] exp_mi;
        logic [7:0] exp_rx;
        int         exp_udf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       mosi;
    logic [7:0] tx_data;
    logic       scl [4];
    logic       ss [4];
    logic       miso [4];
    logic       miso_oe [4];
    logic       tx_valid [4];
    logic       tx_ready [4];
    logic [7:0] rx_data [4];
    logic       rx_valid [4];
    logic       rx_ready [4];
    logic       tx_udf [4];
    logic       rx_ovf [4];

    int n_checks = 0;
    int n_fail   = 0;

    int         cur = 3;
    int         udf_cnt = 0, ovf_cnt = 0, rdy_rise = 0;
    logic       rdy_prev = 1'b1;
    logic [7:0] rx_q [$];
    int         udf_base, ovf_base, rise_base, rxq_base;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_stream #(
            .DATA_W(8), .CPOL(g >= 2), .CPHA(g % 2 == 1), .SYNC_STAGES(2), .IDLE_WORD(8'hFF)
        ) u_dut (
            .clk(clk), .rst(rst), .scl(scl[g]), .ss(ss[g]), .mosi(mosi),
            .miso(miso[g]), .miso_oe(miso_oe[g]),
            .tx_data(tx_data), .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]),
            .rx_data(rx_data[g]), .rx_valid(rx_valid[g]), .rx_ready(rx_ready[g]),
            .tx_udf(tx_udf[g]), .rx_ovf(rx_ovf[g])
        );
    end

    // Observes the instance under test just after each falling clock edge.
    always begin
        @(negedge clk);
        #1;
        if (tx_udf[cur]) udf_cnt++;
        if (rx_ovf[cur]) ovf_cnt++;
        if (tx_ready[cur] && !rdy_prev) rdy_rise++;
        rdy_prev = tx_ready[cur];
        if (rx_valid[cur] && rx_ready[cur]) rx_q.push_back(rx_data[cur]);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic snapshot();
        udf_base  = udf_cnt;
        ovf_base  = ovf_cnt;
        rise_base = rdy_rise;
        rxq_base  = rx_q.size();
    endtask

    task automatic queueTx(input int m, input logic [7:0] w);
        int k = 0;
        @(negedge clk);
        while (!tx_ready[m] && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!tx_ready[m]) checkOutput("tx_ready wait", 32'(tx_ready[m]), 32'd1);
        tx_data     = w;
        tx_valid[m] = 1'b1;
        @(negedge clk);
        tx_valid[m] = 1'b0;
    endtask

    task automatic frameBegin(input int m);
        @(negedge clk);
        ss[m] = 1'b0;
        #(2 * HALF);
    endtask

    task automatic frameEnd(input int m);
        #(HALF);
        ss[m] = 1'b1;
        #(4 * HALF);
    endtask

    task automatic spiWord(input int m, input logic [7:0] mo, output logic [7:0] mi);
        bit cpol = (m >= 2);
        bit cpha = (m % 2 == 1);
        for (int i = 7; i >= 0; i--) begin
            if (!cpha) begin
                mosi = mo[i];
                #(HALF);
                scl[m] = ~cpol;
                mi[i] = miso[m];
                #(HALF);
                scl[m] = cpol;
            end else begin
                scl[m] = ~cpol;
                mosi = mo[i];
                #(HALF);
                scl[m] = cpol;
                mi[i] = miso[m];
                #(HALF);
            end
        end
    endtask

    task automatic applyStimulus(input int m, input bit preload, input logic [7:0] txw,
                                 input word3_t mo, input int nw, output word3_t mi);
        logic [7:0] w;
        cur = m;
        @(negedge clk);
        snapshot();
        if (preload) queueTx(m, txw);
        frameBegin(m);
        for (int k = 0; k < nw; k++) begin
            spiWord(m, mo[k], w);
            mi[k] = w;
        end
        frameEnd(m);
    endtask

    // Reference: first load takes the preloaded word, every later load finds the register empty.
    function automatic logic [7:0] expectRead(input int k, input bit preload, input logic [7:0] txw);
        return (k == 0 && preload) ? txw : 8'hFF;
    endfunction

    task automatic checkRx(input string tag, input word3_t mo, input int nw);
        checkOutput($sformatf("%s rx count", tag), 32'(rx_q.size() - rxq_base), 32'(nw));
        for (int k = 0; k < nw; k++)
            checkOutput($sformatf("%s rx word %0d", tag, k),
                        32'((rx_q.size() > rxq_base + k) ? rx_q[rxq_base + k] : 8'hxx), 32'(mo[k]));
    endtask

    vec_t   vecs [6];
    word3_t mo, mi;

    initial begin
        vecs[0] = '{3, 1'b1, 8'hC3, 8'h5A, 8'hC3, 8'h5A, 1};
        vecs[1] = '{3, 1'b0, 8'h00, 8'h96, 8'hFF, 8'h96, 2};
        vecs[2] = '{0, 1'b1, 8'h3C, 8'hA5, 8'h3C, 8'hA5, 1};
        vecs[3] = '{1, 1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E, 1};
        vecs[4] = '{2, 1'b0, 8'h00, 8'h01, 8'hFF, 8'h01, 2};
        vecs[5] = '{2, 1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 1};

        rst = 1'b1;
        mosi = 1'b0;
        tx_data = 8'h00;
        for (int m = 0; m < 4; m++) begin
            scl[m] = (m >= 2);
            ss[m] = 1'b1;
            tx_valid[m] = 1'b0;
            rx_ready[m] = 1'b1;
        end
        repeat (4) @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            checkOutput($sformatf("reset miso m%0d", m), 32'(miso[m]), 32'd0);
            checkOutput($sformatf("reset miso_oe m%0d", m), 32'(miso_oe[m]), 32'd0);
            checkOutput($sformatf("reset rx_valid m%0d", m), 32'(rx_valid[m]), 32'd0);
            checkOutput($sformatf("reset tx_ready m%0d", m), 32'(tx_ready[m]), 32'd1);
            checkOutput($sformatf("reset rx_data m%0d", m), 32'(rx_data[m]), 32'd0);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] single-word vector table");
        for (int v = 0; v < 6; v++) begin
            mo = '{vecs[v].mo, 8'h00, 8'h00};
            applyStimulus(vecs[v].mode, vecs[v].preload, vecs[v].txw, mo, 1, mi);
            checkOutput($sformatf("vec%0d master read", v), 32'(mi[0]), 32'(vecs[v].exp_mi));
            checkOutput($sformatf("vec%0d rx_data", v), 32'(rx_data[vecs[v].mode]), 32'(vecs[v].exp_rx));
            checkRx($sformatf("vec%0d", v), mo, 1);
            checkOutput($sformatf("vec%0d udf pulses", v), 32'(udf_cnt - udf_base), 32'(vecs[v].exp_udf));
            checkOutput($sformatf("vec%0d ovf pulses", v), 32'(ovf_cnt - ovf_base), 32'd0);
        end

        $display("[TB] back-to-back words in every mode");
        for (int m = 0; m < 4; m++) begin
            mo = '{8'hA5, 8'h3C, 8'h00};
            fork
                applyStimulus(m, 1'b1, 8'hA5, mo, 2, mi);
                begin
                    wait (ss[m] == 1'b0);
                    queueTx(m, 8'h3C);
                end
            join
            checkOutput($sformatf("b2b m%0d read0", m), 32'(mi[0]), 32'hA5);
            checkOutput($sformatf("b2b m%0d read1", m), 32'(mi[1]), 32'h3C);
            checkRx($sformatf("b2b m%0d", m), mo, 2);
            checkOutput($sformatf("b2b m%0d tx_ready rises", m), 32'(rdy_rise - rise_base), 32'd2);
            checkOutput($sformatf("b2b m%0d udf pulses", m), 32'(udf_cnt - udf_base), 32'd1);
        end

        $display("[TB] overflow with rx_ready low");
        rx_ready[3] = 1'b0;
        mo = '{8'h11, 8'h22, 8'h00};
        applyStimulus(3, 1'b0, 8'h00, mo, 2, mi);
        checkOutput("ovf rx_valid held", 32'(rx_valid[3]), 32'd1);
        checkOutput("ovf rx_data kept", 32'(rx_data[3]), 32'h11);
        checkOutput("ovf pulses", 32'(ovf_cnt - ovf_base), 32'd1);
        rx_ready[3] = 1'b1;
        repeat (3) @(negedge clk);
        checkRx("ovf drain", mo, 1);
        checkOutput("ovf rx_valid cleared", 32'(rx_valid[3]), 32'd0);

        $display("[TB] abort after 3 bits");
        cur = 3;
        frameBegin(3);
        for (int i = 0; i < 3; i++) begin
            scl[3] = 1'b0;
            mosi = 1'b1;
            #(HALF);
            scl[3] = 1'b1;
            #(HALF);
        end
        checkOutput("abort miso_oe before", 32'(miso_oe[3]), 32'd1);
        ss[3] = 1'b1;
        #30;
        checkOutput("abort miso_oe within 3 clk", 32'(miso_oe[3]), 32'd0);
        #(3 * HALF);
        mo = '{8'h81, 8'h00, 8'h00};
        applyStimulus(3, 1'b0, 8'h00, mo, 1, mi);
        checkRx("abort", mo, 1);
        checkOutput("abort udf pulses", 32'(udf_cnt - udf_base), 32'd2);

        $display("[TB] reset mid-word");
        frameBegin(3);
        for (int i = 0; i < 3; i++) begin
            scl[3] = 1'b0;
            #(HALF);
            scl[3] = 1'b1;
            #(HALF);
        end
        rst = 1'b1;
        #10;
        checkOutput("rst miso", 32'(miso[3]), 32'd0);
        checkOutput("rst miso_oe", 32'(miso_oe[3]), 32'd0);
        checkOutput("rst rx_valid", 32'(rx_valid[3]), 32'd0);
        checkOutput("rst tx_ready", 32'(tx_ready[3]), 32'd1);
        checkOutput("rst tx_udf", 32'(tx_udf[3]), 32'd0);
        checkOutput("rst rx_ovf", 32'(rx_ovf[3]), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            scl[3] = 1'b0;
            #(HALF);
            scl[3] = 1'b1;
            #(HALF);
        end
        checkOutput("rst waits for new ss fall", 32'(miso_oe[3]), 32'd0);
        ss[3] = 1'b1;
        #(4 * HALF);
        mo = '{8'h5A, 8'h00, 8'h00};
        applyStimulus(3, 1'b1, 8'hC3, mo, 1, mi);
        checkOutput("post-rst master read", 32'(mi[0]), 32'hC3);
        checkRx("post-rst", mo, 1);

        $display("[TB] randomized frames against model");
        for (int it = 0; it < 12; it++) begin
            int         m  = $urandom_range(0, 3);
            bit         pr = 1'($urandom_range(0, 1));
            logic [7:0] tw = 8'($urandom);
            int         nw = $urandom_range(1, 3);
            mo = '{8'($urandom), 8'($urandom), 8'($urandom)};
            applyStimulus(m, pr, tw, mo, nw, mi);
            for (int k = 0; k < nw; k++)
                checkOutput($sformatf("rnd%0d read%0d", it, k), 32'(mi[k]), 32'(expectRead(k, pr, tw)));
            checkRx($sformatf("rnd%0d", it), mo, nw);
            checkOutput($sformatf("rnd%0d udf pulses", it), 32'(udf_cnt - udf_base), 32'(nw + 1 - int'(pr)));
            checkOutput($sformatf("rnd%0d ovf pulses", it), 32'(ovf_cnt - ovf_base), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
